// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction memory loader
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int LEN_W      = 16;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;

  // Byte offset of word index idx, in an address of width 32.
  function automatic logic [31:0] word_offset(input logic [LEN_W-1:0] idx);
    return {{(32-LEN_W){1'b0}}, idx} << 2;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles four little-endian bytes into one 32-bit word
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              start,
  input  logic              clr,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  logic [1:0]                         byte_cnt;
  logic [(WORD_BYTES-1)*BYTE_W-1:0]   lanes;

  // The top lane is never stored: the 4th byte is merged live so the word is
  // available on the same edge that accepts it.
  assign word      = {byte_data, lanes};
  assign word_done = accept && (byte_cnt == 2'(WORD_BYTES - 1));

  // Byte counter and lower three lanes; clear discards any partial word.
  always_ff @(posedge clk) begin
    if (!start || clr) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    lanes[7:0]   <= byte_data;
        2'd1:    lanes[15:8]  <= byte_data;
        2'd2:    lanes[23:16] <= byte_data;
        default: lanes        <= lanes;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: streams a program into instruction memory, then releases the core
module imem_loader
  import loader_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH_WORDS = 256,
  parameter logic [WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              start,
  input  logic              load_req,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [WIDTH-1:0]  imem_addr,
  output logic [WIDTH-1:0]  imem_wdata,
  output logic              cpu_start,
  output logic              busy,
  output logic              err
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic               err_d;
  logic [WIDTH-1:0]   addr_d, wdata_d;
  logic               pack_clr;
  logic               accept;
  logic               word_done;
  logic [WORD_W-1:0]  word;
  logic               oversize;
  logic               len_zero;

  // byte_ready is registered and only high while in LOAD, so it alone gates acceptance.
  assign accept   = byte_valid && byte_ready;
  assign oversize = int'(load_len) > DEPTH_WORDS;
  assign len_zero = (load_len == '0);

  byte_packer u_packer (
    .clk       (clk),
    .start     (start),
    .clr       (pack_clr),
    .accept    (accept),
    .byte_data (byte_data),
    .word      (word),
    .word_done (word_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!start) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus next values for every registered output and counter.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    err_d      = err;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    pack_clr   = 1'b0;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_req) begin
          if (oversize) begin
            err_d = 1'b1;
          end else if (len_zero) begin
            // Empty program: nothing to write, the core is released directly.
            err_d   = 1'b0;
            state_d = ST_RUN;
          end else begin
            err_d      = 1'b0;
            len_d      = load_len;
            word_cnt_d = '0;
            pack_clr   = 1'b1;
            state_d    = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (word_done) begin
          wdata_d = WIDTH'(word);
          addr_d  = BASE_ADDR + WIDTH'(word_offset(word_cnt_q));
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        word_cnt_d = word_cnt_q + LEN_W'(1);
        if ((word_cnt_q + LEN_W'(1)) == len_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and counters, derived from the state being entered so
  // each flag is valid for the whole cycle spent in that state.
  always_ff @(posedge clk) begin
    if (!start) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      err        <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      cpu_start  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      err        <= err_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      byte_ready <= (state_d == ST_LOAD);
      imem_we    <= (state_d == ST_WRITE);
      cpu_start  <= (state_d == ST_RUN);
      busy       <= (state_d == ST_LOAD) || (state_d == ST_WRITE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        start;
  logic        load_req;
  logic [15:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_start;
  logic        busy;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  sent[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic        prev_we = 1'b0;

  imem_loader #(.WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .start      (start),
    .load_req   (load_req),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every memory write and checks strobes never abut.
  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      check("we_not_back_to_back", {31'b0, prev_we}, 32'd0);
    end
    prev_we = imem_we;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'd0);
    check({tag, "_imem_we"},    {31'b0, imem_we},    32'd0);
    check({tag, "_cpu_start"},  {31'b0, cpu_start},  32'd0);
    check({tag, "_busy"},       {31'b0, busy},       32'd0);
    check({tag, "_err"},        {31'b0, err},        32'd0);
    check({tag, "_imem_addr"},  imem_addr,           32'h0);
    check({tag, "_imem_wdata"}, imem_wdata,          32'h0);
  endtask

  task automatic do_reset(input int cycles);
    start = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    start = 1'b1;
  endtask

  task automatic start_load(input logic [15:0] len);
    load_req = 1'b1;
    load_len = len;
    step();
    load_req = 1'b0;
    load_len = 16'($urandom);
  endtask

  // Queue n random bytes (plus remembers them for the model).
  task automatic prepare_random(input int n);
    tx_q.delete();
    sent.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      tx_q.push_back(b);
      sent.push_back(b);
    end
  endtask

  // mode 0: valid held high, 1: valid toggles, 2: random valid.
  task automatic send_bytes(input int mode);
    int  guard;
    bit  fire;
    guard = 0;
    while (tx_q.size() != 0 && guard < 2000) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = ~byte_valid;
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_data = byte_valid ? tx_q[0] : 8'($urandom);
      fire = byte_valid && byte_ready;
      step();
      if (fire) tx_q.delete(0);
      guard++;
    end
    byte_valid = 1'b0;
    check("bytes_drained", tx_q.size(), 32'd0);
  endtask

  task automatic wait_run();
    int g;
    g = 0;
    while (!cpu_start && g < 100) begin
      step();
      g++;
    end
    check("run_reached", {31'b0, cpu_start}, 32'd1);
  endtask

  // Reference: word i is bytes 4i..4i+3 little-endian, written at BASE + 4i.
  task automatic check_writes(input int nwords);
    step();
    step();
    check("write_count", got_addr.size(), nwords);
    for (int i = 0; i < nwords && i < got_addr.size(); i++) begin
      logic [31:0] exp_word;
      exp_word = {sent[4*i+3], sent[4*i+2], sent[4*i+1], sent[4*i]};
      check("write_addr", got_addr[i], 32'(4 * i));
      check("write_data", got_data[i], exp_word);
    end
    got_addr.delete();
    got_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    start      = 1'b0;
    load_req   = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = '0;

    // Reset state.
    do_reset(3);
    check_idle_outputs("reset");

    // Two-word program with continuous valid; cycle-exact handshake checks.
    tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    sent = tx_q;
    start_load(16'd2);
    check("load_byte_ready_t1", {31'b0, byte_ready}, 32'd1);
    check("load_busy", {31'b0, busy}, 32'd1);
    send_bytes(0);
    check("last_byte_we", {31'b0, imem_we}, 32'd1);
    check("last_byte_no_start", {31'b0, cpu_start}, 32'd0);
    step();
    check("start_after_write", {31'b0, cpu_start}, 32'd1);
    check("idle_busy_in_run", {31'b0, busy}, 32'd0);
    check("tp_word0", (got_data.size() > 0) ? got_data[0] : 32'hdeadbeef, 32'h00000013);
    check_writes(2);

    // Same program with toggling valid; reload from RUN drops the core first.
    tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    sent = tx_q;
    start_load(16'd2);
    check("reload_drops_start", {31'b0, cpu_start}, 32'd0);
    send_bytes(1);
    wait_run();
    check_writes(2);

    // Random programs with random valid gaps.
    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(1, 6);
      prepare_random(4 * len);
      start_load(16'(len));
      check("rand_reload_drop", {31'b0, cpu_start}, 32'd0);
      send_bytes(2);
      wait_run();
      check_writes(len);
    end

    // Zero-length load from IDLE goes straight to RUN.
    do_reset(1);
    start_load(16'd0);
    check("len0_run", {31'b0, cpu_start}, 32'd1);
    check("len0_busy", {31'b0, busy}, 32'd0);
    check_writes(0);

    // Oversize from IDLE: err set, still idle; then a legal load clears it.
    do_reset(1);
    start_load(16'(DEPTH + 1));
    check("over_err", {31'b0, err}, 32'd1);
    check("over_busy", {31'b0, busy}, 32'd0);
    check("over_no_start", {31'b0, cpu_start}, 32'd0);
    check("over_no_ready", {31'b0, byte_ready}, 32'd0);
    check_writes(0);
    check("over_err_sticky", {31'b0, err}, 32'd1);
    prepare_random(4);
    start_load(16'd1);
    check("err_cleared", {31'b0, err}, 32'd0);
    send_bytes(0);
    wait_run();
    check_writes(1);

    // Reset after three bytes discards the partial word.
    prepare_random(3);
    start_load(16'd1);
    send_bytes(0);
    start = 1'b0;
    step();
    start = 1'b1;
    check_idle_outputs("midword");
    check_writes(0);
    prepare_random(4);
    start_load(16'd1);
    send_bytes(2);
    wait_run();
    check_writes(1);

    // Reload while running: core dropped, one write at base, core released.
    prepare_random(4);
    start_load(16'd1);
    check("run_reload_drop", {31'b0, cpu_start}, 32'd0);
    send_bytes(0);
    wait_run();
    check_writes(1);

    // Oversize while running: err set, core keeps running.
    start_load(16'hffff);
    check("run_over_err", {31'b0, err}, 32'd1);
    check("run_over_start", {31'b0, cpu_start}, 32'd1);
    check_writes(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot/load controller that sequences the single-cycle RISC-V core. It holds the core in reset, accepts a program as a byte stream over a valid/ready handshake, and packs it little-endian into 32-bit words. Each word is written to consecutive word addresses of instruction memory; when the programmed word count is reached, it releases the core by driving its `start` input high. A new load request while running drops the core back into reset and reloads.

## Interface
Parameters:
- `WIDTH`, 32: instruction/address width.
- `DEPTH_WORDS`, 256: instruction memory capacity in words.
- `BASE_ADDR`, 32'h0: byte address of the first loaded word; word-aligned.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `start`, in, 1: reset, synchronous, active-low.
- `load_req`, in, 1: single-cycle request to begin a load.
- `load_len`, in, 16: number of words to load; sampled when `load_req` is accepted.
- `byte_valid`, in, 1: source has a byte on `byte_data`.
- `byte_data`, in, 8: program byte.
- `byte_ready`, out, 1: loader accepts a byte this cycle.
- `imem_we`, out, 1: instruction memory write strobe.
- `imem_addr`, out, `WIDTH`: byte address of the write; word-aligned.
- `imem_wdata`, out, `WIDTH`: word to write.
- `cpu_start`, out, 1: drives the core's `start`; 0 holds the core in reset.
- `busy`, out, 1: high in LOAD or WRITE.
- `err`, out, 1: sticky; set when `load_len` > `DEPTH_WORDS`.

## Operation
- States: IDLE, LOAD, WRITE, RUN.
- Reset values (`start`=0 at an edge):
  - state is IDLE.
  - `byte_ready`, `imem_we`, `cpu_start`, `busy` and `err` are 0.
  - `imem_addr` is `BASE_ADDR`; `imem_wdata` is 0.
  - Byte counter and word counter are 0.
  - Any partial word is discarded.
- IDLE, on `load_req`:
  - If `load_len` > `DEPTH_WORDS`: `err` is set and the state stays IDLE.
  - If `load_len` == 0: go to RUN; `err` is cleared.
  - Otherwise: latch `load_len`, clear both counters and `err`, go to LOAD.
- LOAD:
  - `byte_ready`=1.
  - On `byte_valid && byte_ready`, the byte goes into lane `byte_cnt` (lane 0 = bits [7:0]) and `byte_cnt` increments modulo 4.
  - Accepting the 4th byte registers the packed word and moves to WRITE.
- WRITE (one cycle):
  - `byte_ready`=0 and `imem_we`=1.
  - `imem_addr` = `BASE_ADDR` + 4×`word_cnt`.
  - `word_cnt` increments.
  - If the incremented count equals the latched length, go to RUN; otherwise return to LOAD.
- RUN:
  - `cpu_start`=1 and `byte_ready`=0.
  - `load_req` with a valid length drops `cpu_start` the same edge and goes to LOAD, so the core sees reset.
  - `load_req` with an oversize length sets `err` and stays in RUN.
- `load_req` is ignored in LOAD and WRITE.
- `byte_valid` is ignored outside LOAD.
- Address arithmetic wraps modulo 2^`WIDTH`; this cannot occur with legal lengths.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `load_req` sampled at edge t:
  - LOAD is entered at t.
  - `byte_ready`=1 during cycle t+1.
- 4th byte accepted at edge k:
  - `imem_we`=1 during cycle k+1.
  - At edge k+2: LOAD with `byte_ready`=1, or RUN with `cpu_start`=1.
- Peak throughput is 1 word per 5 cycles.
- `imem_we` is never high in two consecutive cycles.
- `start` low has priority over every other input in the same cycle.

## Structure
- Shared package `loader_pkg`:
  - State enum (IDLE/LOAD/WRITE/RUN).
  - `LEN_W`=16.
  - Word-byte count constant 4.
- One sub-module, `byte_packer`:
  - Byte counter and 4-lane shift/assemble register.
  - Inputs: `clk`, `start`, `clr`, `accept`, `byte_data`.
  - Outputs: `word`, `word_done`.
- FSM, word counter, address generation and `err` live in the top level.

## Test plan
- Reset then `load_req`, `load_len`=2, bytes 13 00 00 00 93 00 10 00 with continuous valid:
  - Writes 0x00000013 at 0x0, then 0x00100093 at 0x4.
  - `cpu_start` rises 2 cycles after the 8th byte.
- Same load with `byte_valid` toggling every other cycle: identical writes; no byte dropped or duplicated.
- `load_len`=0: RUN one edge after `load_req`; no `imem_we`.
- `load_len`=`DEPTH_WORDS`+1: `err`=1, stays IDLE, no writes. A following `load_len`=1 clears `err`.
- Reset mid-word (after 3 bytes, `start`=0 for 1 cycle): all outputs 0. A new 1-word load writes the new bytes only, at `BASE_ADDR`.
- In RUN, `load_req` with `load_len`=1:
  - `cpu_start` falls the next cycle.
  - One write occurs at `BASE_ADDR`.
  - `cpu_start` rises again.
